// File: rtl/hazard_scoreboard.sv
// Scoreboard-driven hazard unit: operand forwarding selects, load-use stalls and branch flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(NREG),
    localparam int unsigned FW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] ra1_d,
    input  logic [AW-1:0] ra2_d,
    input  logic          use1_d,
    input  logic          use2_d,
    input  logic [AW-1:0] wa_d,
    input  logic          we_d,
    input  logic          load_d,
    input  logic          branch_taken_e,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic [FW-1:0] fwd_a_e,
    output logic [FW-1:0] fwd_b_e,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);

    localparam logic [AW-1:0] PC_REG = AW'(NREG - 1);

    // Entry k mirrors stage E+k; only the Execute entry keeps its sources and load flag.
    logic [DEPTH:0] vld_q;
    logic [DEPTH:0] we_q;
    logic [AW-1:0]  wa_q [DEPTH+1];
    logic           load_q;
    logic           use1_q;
    logic           use2_q;
    logic [AW-1:0]  ra1_q;
    logic [AW-1:0]  ra2_q;

    logic br;
    logic hit1;
    logic hit2;
    logic lu;
    logic src_a_ok;
    logic src_b_ok;

    // Branch is masked while reset is held so every output reads zero during reset.
    assign br   = branch_taken_e & reset;
    assign hit1 = use1_d & (ra1_d == wa_q[0]) & (ra1_d != PC_REG);
    assign hit2 = use2_d & (ra2_d == wa_q[0]) & (ra2_d != PC_REG);
    assign lu   = vld_q[0] & load_q & we_q[0] & (hit1 | hit2);

    assign stall_f = lu & ~br;
    assign stall_d = lu & ~br;
    assign flush_e = lu | br;
    assign flush_d = br;

    // Scoreboard shift; a flushed Execute slot becomes an all-zero bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            we_q   <= '0;
            load_q <= 1'b0;
            use1_q <= 1'b0;
            use2_q <= 1'b0;
            ra1_q  <= '0;
            ra2_q  <= '0;
            for (int unsigned k = 0; k <= DEPTH; k++) begin
                wa_q[k] <= '0;
            end
        end else if (en) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                we_q[k]  <= we_q[k-1];
                wa_q[k]  <= wa_q[k-1];
            end
            if (flush_e) begin
                vld_q[0] <= 1'b0;
                we_q[0]  <= 1'b0;
                wa_q[0]  <= '0;
                load_q   <= 1'b0;
                use1_q   <= 1'b0;
                use2_q   <= 1'b0;
                ra1_q    <= '0;
                ra2_q    <= '0;
            end else begin
                vld_q[0] <= 1'b1;
                we_q[0]  <= we_d;
                wa_q[0]  <= wa_d;
                load_q   <= load_d;
                use1_q   <= use1_d;
                use2_q   <= use2_d;
                ra1_q    <= ra1_d;
                ra2_q    <= ra2_d;
            end
        end
    end

    assign src_a_ok = vld_q[0] & use1_q & (ra1_q != PC_REG);
    assign src_b_ok = vld_q[0] & use2_q & (ra2_q != PC_REG);

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a_e = '0;
        fwd_b_e = '0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (src_a_ok && vld_q[k] && we_q[k] && (wa_q[k] == ra1_q)) begin
                fwd_a_e = FW'(k);
            end
            if (src_b_ok && vld_q[k] && we_q[k] && (wa_q[k] == ra2_q)) begin
                fwd_b_e = FW'(k);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters, sampled only on enabled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (en) begin
            if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((flush_d || flush_e) && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
